mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS core: the parametrised successor to the single-cycle decoder. It sequences every instruction through fetch/decode/execute/memory/writeback states and stalls on a shared instruction/data memory handshake. It adds an extended ISA subset, a memory-wait timeout with sticky halt, and a retired-instruction counter. It sits between the IR/PC/regfile/ALU datapath and the unified memory port.

## Interface
- EXT_ISA, 1, 1 enables bne/lui/j and R-type and/slt; 0 decodes them as illegal.
- TIMEOUT, 15, max cycles waiting on mem_ready per access; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current IR contents (opcode [31:26], funct [5:0])
- breq  in  1  regfile rs==rt comparison; sampled only in EX
- mem_ready  in  1  memory accepts/completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_sel  out  1  0 = address from PC (fetch), 1 = address from ALU result (data)
- mem_we  out  1  data write (sw)
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_we  out  1  regfile write enable
- wd_sel  out  2  0 = ALU, 1 = MEM, 2 = PC (already PC+4)
- rd_sel  out  2  0 = rd, 1 = rt, 2 = $31
- bsel  out  1  ALU B = immediate (ori/lui/lw/sw)
- alu_op  out  3  0 ADD, 1 ADDU, 2 SUBU, 3 OR, 4 AND, 5 SLT, 6 LUI
- state  out  3  current state encoding
- halted  out  1  sticky; set on illegal instruction or timeout
- instret  out  CNT_W  retired-instruction count

## Operation
- Decode: opcode R=0x00 (funct addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2a), ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, bne 0x05, j 0x02, jal 0x03. Any other opcode or R funct is illegal. EXT_ISA gating applies as listed under Interface.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- IF: mem_req=1, mem_sel=0. On mem_ready: ir_we=1, pc_we=1, pc_sel=0, go to ID. Otherwise hold in IF.
- ID:
  - jal: reg_we=1, wd_sel=2, rd_sel=2, pc_we=1, pc_sel=2, retire, go to IF.
  - j: pc_we=1, pc_sel=2, retire, go to IF.
  - Illegal: go to HALT; no enables asserted.
  - All others: go to EX.
- EX: alu_op and bsel are driven per instruction.
  - beq: pc_we=breq. bne: pc_we=!breq. Both use pc_sel=1, retire, go to IF.
  - lw/sw: alu_op=ADD, bsel=1, go to MEM.
  - R/ori/lui: go to WB.
- MEM: mem_req=1, mem_sel=1, mem_we=(sw). On mem_ready: sw retires and goes to IF; lw goes to WB.
- WB: reg_we=1. R-type uses rd_sel=0, wd_sel=0. ori/lui use rd_sel=1, wd_sel=0. lw uses rd_sel=1, wd_sel=1. Retire, go to IF.
- alu_op and bsel hold their EX values through MEM and WB of the same instruction. In other states they are 0.
- Timeout:
  - A wait counter clears on entry to IF or MEM and increments each cycle mem_ready=0 in those states.
  - If the counter reaches TIMEOUT with mem_ready still 0, go to HALT.
  - mem_ready=1 on the same cycle the counter reaches TIMEOUT counts as success.
- HALT: all enables and mem_req are 0, halted=1, instret frozen. Only reset exits HALT.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.

## Timing
- state, wait counter, halted and instret are registered. All other outputs are combinational from state, instr, breq and mem_ready.
- Reset (asynchronous, takes effect immediately): state=IF, halted=0, instret=0, counter=0.
  - While rst_n=0, outputs are mem_req=1, mem_sel=0 and all other outputs 0. The state does not advance even if mem_ready=1.
- Zero-wait-state latency per instruction: j/jal 2 cycles, beq/bne 3, R/ori/lui/sw 4, lw 5. Each mem_ready=0 cycle adds 1.
- mem_req and mem_we stay stable until the mem_ready cycle. The request completes on the edge ending the mem_ready=1 cycle.
- Reset mid-MEM abandons the access; mem_we drops asynchronously.
- instr must be stable from ID through WB. The IR loads only at the IF exit edge.

## Test plan
- addu (funct 0x21), mem_ready tied 1 -> IF/ID/EX/WB over 4 cycles; WB shows reg_we=1, rd_sel=0, alu_op=1; instret 0->1.
- lw with mem_ready low for 3 MEM cycles -> 8 cycles total; mem_sel=1 and mem_we=0 held; WB wd_sel=1, rd_sel=1.
- beq with breq=1 -> pc_we=1, pc_sel=1 in EX. bne with breq=1 -> pc_we=0. Both take 3 cycles.
- jal -> in ID: reg_we=1, rd_sel=2, wd_sel=2, pc_sel=2; back in IF next cycle.
- Opcode 0x3f -> HALT after ID, halted=1, mem_req=0 forever. EXT_ISA=0 with lui -> same result.
- TIMEOUT=4, mem_ready held 0 in IF -> HALT after 4 wait cycles. Re-run with mem_ready=1 on the 4th cycle -> proceeds to ID. Async reset mid-lw -> state=IF and instret=0 immediately.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit sequencing IF/ID/EX/MEM/WB over a shared
// memory port, with a memory-wait timeout, sticky halt and retired-instruction counter.
module mc_ctrl #(
    parameter bit EXT_ISA = 1'b1,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             breq_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_sel_o,
    output logic             mem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             reg_we_o,
    output logic [1:0]       wd_sel_o,
    output logic [1:0]       rd_sel_o,
    output logic             bsel_o,
    output logic [2:0]       alu_op_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_ORI, OP_LUI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ILL
    } op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    op_e              op;
    logic [2:0]       alu_ex;
    logic             is_r, is_imm, is_mem, is_br, is_jmp;
    logic             waiting, tmo, retire;
    logic             unused_instr;

    assign unused_instr = ^instr_i[25:6];

    // Extended ops decode as illegal when EXT_ISA is off.
    always_comb begin
        op = OP_ILL;
        case (instr_i[31:26])
            6'h00: begin
                case (instr_i[5:0])
                    6'h21:   op = OP_ADDU;
                    6'h23:   op = OP_SUBU;
                    6'h24:   op = EXT_ISA ? OP_AND : OP_ILL;
                    6'h25:   op = OP_OR;
                    6'h2a:   op = EXT_ISA ? OP_SLT : OP_ILL;
                    default: op = OP_ILL;
                endcase
            end
            6'h0d:   op = OP_ORI;
            6'h0f:   op = EXT_ISA ? OP_LUI : OP_ILL;
            6'h23:   op = OP_LW;
            6'h2b:   op = OP_SW;
            6'h04:   op = OP_BEQ;
            6'h05:   op = EXT_ISA ? OP_BNE : OP_ILL;
            6'h02:   op = EXT_ISA ? OP_J : OP_ILL;
            6'h03:   op = OP_JAL;
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_ex = 3'd0;
        case (op)
            OP_ADDU:      alu_ex = 3'd1;
            OP_SUBU:      alu_ex = 3'd2;
            OP_OR,
            OP_ORI:       alu_ex = 3'd3;
            OP_AND:       alu_ex = 3'd4;
            OP_SLT:       alu_ex = 3'd5;
            OP_LUI:       alu_ex = 3'd6;
            default:      alu_ex = 3'd0;
        endcase
    end

    assign is_r   = op inside {OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT};
    assign is_mem = op inside {OP_LW, OP_SW};
    assign is_imm = is_mem || op == OP_ORI || op == OP_LUI;
    assign is_br  = op inside {OP_BEQ, OP_BNE};
    assign is_jmp = op inside {OP_J, OP_JAL};

    // A ready on the cycle the count would reach TIMEOUT still completes the access.
    assign waiting = (state_q == S_IF || state_q == S_MEM) && !mem_ready_i;
    assign tmo     = (TIMEOUT != 0) && waiting && cnt_q == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    state_d = mem_ready_i ? S_ID : (tmo ? S_HALT : S_IF);
            S_ID:    state_d = (op == OP_ILL) ? S_HALT : (is_jmp ? S_IF : S_EX);
            S_EX:    state_d = is_mem ? S_MEM : (is_br ? S_IF : S_WB);
            S_MEM:   state_d = mem_ready_i ? ((op == OP_SW) ? S_IF : S_WB) : (tmo ? S_HALT : S_MEM);
            S_WB:    state_d = S_IF;
            default: state_d = S_HALT;
        endcase
    end

    assign cnt_d     = (state_d != state_q) ? '0 : (waiting ? cnt_q + CW'(1) : cnt_q);
    assign halted_d  = halted_q || state_d == S_HALT;
    assign instret_d = instret_q + CNT_W'(retire);

    always_comb begin
        mem_req_o = 1'b0;
        mem_sel_o = 1'b0;
        mem_we_o  = 1'b0;
        ir_we_o   = 1'b0;
        pc_we_o   = 1'b0;
        pc_sel_o  = 2'd0;
        reg_we_o  = 1'b0;
        wd_sel_o  = 2'd0;
        rd_sel_o  = 2'd0;
        bsel_o    = 1'b0;
        alu_op_o  = 3'd0;
        retire    = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ready_i && rst_n;
                pc_we_o   = mem_ready_i && rst_n;
            end
            S_ID: begin
                if (is_jmp) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = 2'd2;
                    reg_we_o = op == OP_JAL;
                    wd_sel_o = (op == OP_JAL) ? 2'd2 : 2'd0;
                    rd_sel_o = (op == OP_JAL) ? 2'd2 : 2'd0;
                    retire   = 1'b1;
                end
            end
            S_EX: begin
                alu_op_o = alu_ex;
                bsel_o   = is_imm;
                if (is_br) begin
                    pc_sel_o = 2'd1;
                    pc_we_o  = (op == OP_BEQ) ? breq_i : !breq_i;
                    retire   = 1'b1;
                end
            end
            S_MEM: begin
                alu_op_o  = alu_ex;
                bsel_o    = is_imm;
                mem_req_o = 1'b1;
                mem_sel_o = 1'b1;
                mem_we_o  = op == OP_SW;
                retire    = op == OP_SW && mem_ready_i;
            end
            S_WB: begin
                alu_op_o = alu_ex;
                bsel_o   = is_imm;
                reg_we_o = 1'b1;
                rd_sel_o = is_r ? 2'd0 : 2'd1;
                wd_sel_o = (op == OP_LW) ? 2'd1 : 2'd0;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign halted_o  = halted_q;
    assign instret_o = instret_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random and directed instruction streams for mc_ctrl, checked cycle by
// cycle against per-instruction phase sequences built from the ISA timing rules.
module tb_mc_ctrl;
    localparam int K_ADDU = 0, K_SLT = 4, K_ORI = 5, K_LUI = 6, K_LW = 7, K_SW = 8;
    localparam int K_BEQ = 9, K_BNE = 10, K_J = 11, K_JAL = 12;
    localparam logic [19:0] ALL = 20'hfffff;
    localparam logic [19:0] NOALU = 20'hffff8;

    typedef struct packed {
        logic        rdy;
        logic        ret;
        logic [19:0] exp;
        logic [19:0] msk;
    } cyc_t;

    logic        clk = 1'b0, rst_n = 1'b1, breq = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] instr2 = 32'h3c00_0000;
    logic        mem_req, mem_sel, mem_we, ir_we, pc_we, reg_we, bsel, halted;
    logic [1:0]  pc_sel, wd_sel, rd_sel;
    logic [2:0]  alu_op, state;
    logic [7:0]  instret;
    logic        mem_req2, mem_sel2, mem_we2, ir_we2, pc_we2, reg_we2, bsel2, halted2;
    logic [1:0]  pc_sel2, wd_sel2, rd_sel2;
    logic [2:0]  alu_op2, state2;
    logic [31:0] instret2;
    logic [19:0] ctrl, ctrl2;
    logic [19:0] ifw_v, ifr_v, id0_v, rst_v, hlt_v;
    logic [7:0]  exp_ret = 8'd0;
    cyc_t        seq[$];
    int          n_chk = 0, n_pass = 0;
    int          opc_t[13] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h0d, 'h0f, 'h23, 'h2b, 'h04, 'h05, 'h02, 'h03};
    int          fn_t[13]  = '{'h21, 'h23, 'h24, 'h25, 'h2a, 0, 0, 0, 0, 0, 0, 0, 0};
    int          alu_t[13] = '{1, 2, 4, 3, 5, 3, 6, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    mc_ctrl #(.EXT_ISA(1'b1), .TIMEOUT(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .breq_i(breq), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_sel_o(mem_sel), .mem_we_o(mem_we), .ir_we_o(ir_we),
        .pc_we_o(pc_we), .pc_sel_o(pc_sel), .reg_we_o(reg_we), .wd_sel_o(wd_sel),
        .rd_sel_o(rd_sel), .bsel_o(bsel), .alu_op_o(alu_op), .state_o(state),
        .halted_o(halted), .instret_o(instret)
    );

    mc_ctrl #(.EXT_ISA(1'b0), .TIMEOUT(15), .CNT_W(32)) u_noext (
        .clk(clk), .rst_n(rst_n), .instr_i(instr2), .breq_i(breq), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req2), .mem_sel_o(mem_sel2), .mem_we_o(mem_we2), .ir_we_o(ir_we2),
        .pc_we_o(pc_we2), .pc_sel_o(pc_sel2), .reg_we_o(reg_we2), .wd_sel_o(wd_sel2),
        .rd_sel_o(rd_sel2), .bsel_o(bsel2), .alu_op_o(alu_op2), .state_o(state2),
        .halted_o(halted2), .instret_o(instret2)
    );

    assign ctrl  = {halted, state, mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel,
                    reg_we, wd_sel, rd_sel, bsel, alu_op};
    assign ctrl2 = {halted2, state2, mem_req2, mem_sel2, mem_we2, ir_we2, pc_we2, pc_sel2,
                    reg_we2, wd_sel2, rd_sel2, bsel2, alu_op2};

    function automatic logic [19:0] cw(input int st, input bit req, input bit sel, input bit we,
                                       input bit irw, input bit pcw, input int pcs, input bit rw,
                                       input int wds, input int rds, input bit bs, input int alu);
        return {st == 7, 3'(st), req, sel, we, irw, pcw, 2'(pcs), rw, 2'(wds), 2'(rds), bs, 3'(alu)};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] mk(input int k);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'(opc_t[k]);
        if (k <= K_SLT) w[5:0] = 6'(fn_t[k]);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic r, input logic t, input logic [19:0] e, input logic [19:0] m);
        seq.push_back({r, t, e, m});
    endtask

    task automatic push_halt(input int n);
        repeat (n) push(rnd(), 1'b0, hlt_v, ALL);
    endtask

    // Expected cycle sequence of one instruction: fetch waits, then its class-specific phases.
    task automatic build(input int k, input int wif, input int wmem, input logic br);
        logic mem, imm, sw, jal;
        mem = k == K_LW || k == K_SW;
        sw  = k == K_SW;
        jal = k == K_JAL;
        imm = mem || k == K_ORI || k == K_LUI;
        seq.delete();
        repeat (wif) push(1'b0, 1'b0, ifw_v, ALL);
        push(1'b1, 1'b0, ifr_v, ALL);
        if (k == K_J || k == K_JAL) begin
            push(rnd(), 1'b1, cw(1, 0, 0, 0, 0, 1, 2, jal, jal ? 2 : 0, jal ? 2 : 0, 0, 0), ALL);
        end else begin
            push(rnd(), 1'b0, id0_v, ALL);
            if (k == K_BEQ || k == K_BNE) begin
                push(rnd(), 1'b1, cw(2, 0, 0, 0, 0, (k == K_BEQ) ? br : !br, 1, 0, 0, 0, 0, 0), NOALU);
            end else begin
                push(rnd(), 1'b0, cw(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, imm, alu_t[k]), ALL);
                if (mem) begin
                    repeat (wmem) push(1'b0, 1'b0, cw(3, 1, 1, sw, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
                    push(1'b1, sw, cw(3, 1, 1, sw, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
                end
                if (!sw)
                    push(rnd(), 1'b1, cw(4, 0, 0, 0, 0, 0, 0, 1, (k == K_LW) ? 1 : 0,
                                         (k <= K_SLT) ? 0 : 1, imm, alu_t[k]), ALL);
            end
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic play(input string tag, input int n);
        cyc_t c;
        while (seq.size() != 0 && n != 0) begin
            c = seq.pop_front();
            mem_ready = c.rdy;
            #1;
            check({tag, "_ctrl"}, 32'(ctrl & c.msk), 32'(c.exp & c.msk));
            check({tag, "_instret"}, 32'(instret), 32'(exp_ret));
            if (c.ret) exp_ret = exp_ret + 8'd1;
            @(negedge clk);
            n--;
        end
    endtask

    task automatic run(input string tag, input int k, input int wif, input int wmem, input logic br);
        instr = mk(k);
        breq  = br;
        build(k, wif, wmem, br);
        play(tag, -1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ctrl", 32'(ctrl), 32'(rst_v));
            check("rst_instret", 32'(instret), 32'd0);
            check("rst_ctrl2", 32'(ctrl2), 32'(rst_v));
            @(negedge clk);
        end
        rst_n   = 1'b1;
        exp_ret = 8'd0;
        seq.delete();
    endtask

    initial begin
        ifw_v = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ifr_v = cw(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        id0_v = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_v = ifw_v;
        hlt_v = cw(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        do_reset();
        run("addu", K_ADDU, 0, 0, 1'b0);
        check("noext_lui_halt", 32'(ctrl2), 32'(hlt_v));
        check("noext_instret", instret2, 32'd0);
        run("lw_wait3", K_LW, 0, 3, 1'b0);
        run("beq_taken", K_BEQ, 0, 0, 1'b1);
        run("bne_eq", K_BNE, 0, 0, 1'b1);
        run("jal", K_JAL, 0, 0, 1'b0);
        run("j", K_J, 0, 0, 1'b0);
        run("if_ready_4th", K_ADDU, 3, 0, 1'b0);
        for (int i = 0; i < 300; i++)
            run("rand", $urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3), rnd());
        instr = mk(K_ADDU);
        seq.delete();
        repeat (4) push(1'b0, 1'b0, ifw_v, ALL);
        push_halt(5);
        play("if_timeout", -1);
        do_reset();
        instr = 32'hfc00_0000;
        push(1'b1, 1'b0, ifr_v, ALL);
        push(rnd(), 1'b0, id0_v, ALL);
        push_halt(4);
        play("ill_op3f", -1);
        do_reset();
        instr = 32'h0000_0020;
        push(1'b1, 1'b0, ifr_v, ALL);
        push(rnd(), 1'b0, id0_v, ALL);
        push_halt(3);
        play("ill_funct", -1);
        do_reset();
        instr = mk(K_LW);
        push(1'b1, 1'b0, ifr_v, ALL);
        push(rnd(), 1'b0, id0_v, ALL);
        push(rnd(), 1'b0, cw(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
        repeat (4) push(1'b0, 1'b0, cw(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
        push_halt(3);
        play("mem_timeout", -1);
        do_reset();
        run("addu2", K_ADDU, 0, 0, 1'b0);
        instr = mk(K_SW);
        build(K_SW, 0, 3, 1'b0);
        play("sw_pre", 4);
        mem_ready = 1'b0;
        #2;
        check("sw_mem_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(ctrl), 32'(rst_v));
        check("mid_rst_instret", 32'(instret), 32'd0);
        seq.delete();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
